// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the funct3 values that have no legal meaning.
package lsu_pkg;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    // funct3[2] means "unsigned" for loads; no store encoding uses it.
    localparam int         F3_UNSIGNED_BIT = 2;
    localparam logic [2:0] F3_LOAD_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;
endpackage

// File: rtl/lsu_dmem_if.sv
// Data-memory req/ack bus between the LSU (master) and the memory (slave).
interface lsu_dmem_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wmask;
    logic [63:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
        input  dmem_rdata, dmem_ack
    );
    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: legality check, store mask/data placement
// and load lane extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic        is_store_i,
    input  logic [63:0] store_data_i,
    input  logic [63:0] rdata_i,
    output logic        illegal_o,
    output logic [7:0]  wmask_o,
    output logic [63:0] wdata_o,
    output logic [63:0] ldata_o
);
    logic        sext;
    logic [63:0] lane;

    assign sext    = ~funct3_i[F3_UNSIGNED_BIT];
    assign lane    = rdata_i >> {off_i, 3'b000};
    assign wdata_o = store_data_i << {off_i, 3'b000};

    always_comb begin
        illegal_o = 1'b0;
        wmask_o   = 8'hFF;
        ldata_o   = lane;
        case (funct3_i[1:0])
            SZ_B: begin
                wmask_o = 8'h01 << off_i;
                ldata_o = {{56{sext & lane[7]}}, lane[7:0]};
            end
            SZ_H: begin
                illegal_o = off_i[0];
                wmask_o   = 8'h03 << off_i;
                ldata_o   = {{48{sext & lane[15]}}, lane[15:0]};
            end
            SZ_W: begin
                illegal_o = (off_i[1:0] != 2'b00);
                wmask_o   = 8'h0F << off_i;
                ldata_o   = {{32{sext & lane[31]}}, lane[31:0]};
            end
            default: begin
                illegal_o = (off_i != 3'b000);
            end
        endcase
        // Encodings that are illegal regardless of alignment.
        if (is_store_i ? funct3_i[F3_UNSIGNED_BIT] : (funct3_i == F3_LOAD_ILLEGAL))
            illegal_o = 1'b1;
    end
endmodule

// File: rtl/lsu_mem_stage.sv
// RV64 load/store stage: accepts one access from the ALU, runs it over the
// req/ack bus while stalling the core, and reports done/misalign/bus_err.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          is_load_i,
    input  logic          is_store_i,
    input  logic [2:0]    funct3_i,
    input  logic [63:0]   addr_i,
    input  logic [63:0]   store_data_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [63:0]   load_data_o,
    output logic          misalign_o,
    output logic          bus_err_o,
    lsu_dmem_if.master    dmem
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    lsu_state_e     state_q, state_d;
    logic [63:0]    addr_q, addr_d;
    logic [63:0]    sdata_q, sdata_d;
    logic [2:0]     funct3_q, funct3_d;
    logic           we_q, we_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           misalign_q, misalign_d;
    logic           bus_err_q, bus_err_d;
    logic [63:0]    load_data_q, load_data_d;

    logic           idle, in_req, accept, expire;
    logic           al_illegal;
    logic [7:0]     al_wmask;
    logic [63:0]    al_wdata, al_ldata;

    assign idle   = (state_q == IDLE);
    assign in_req = (state_q == REQ);
    assign accept = start_i & (is_load_i | is_store_i);
    assign expire = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // In IDLE the aligner judges the incoming access; afterwards it works
    // on the latched copy so the bus stays stable until ack.
    lsu_align u_align (
        .off_i        (idle ? addr_i[2:0] : addr_q[2:0]),
        .funct3_i     (idle ? funct3_i : funct3_q),
        .is_store_i   (idle ? is_store_i : we_q),
        .store_data_i (sdata_q),
        .rdata_i      (dmem.dmem_rdata),
        .illegal_o    (al_illegal),
        .wmask_o      (al_wmask),
        .wdata_o      (al_wdata),
        .ldata_o      (al_ldata)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        sdata_d     = sdata_q;
        funct3_d    = funct3_q;
        we_d        = we_q;
        cnt_d       = '0;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        load_data_d = load_data_q;
        busy_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d   = addr_i;
                    sdata_d  = store_data_i;
                    funct3_d = funct3_i;
                    we_d     = is_store_i;
                    if (al_illegal) begin
                        state_d    = DONE;
                        misalign_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        busy_o  = 1'b1;
                    end
                end
            end
            REQ: begin
                busy_o = 1'b1;
                if (dmem.dmem_ack) begin
                    state_d = DONE;
                    if (!we_q) load_data_d = al_ldata;
                end else if (expire) begin
                    state_d   = DONE;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            sdata_q     <= '0;
            funct3_q    <= '0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            sdata_q     <= sdata_d;
            funct3_q    <= funct3_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
            load_data_q <= load_data_d;
        end
    end

    assign done_o      = (state_q == DONE);
    assign misalign_o  = misalign_q;
    assign bus_err_o   = bus_err_q;
    assign load_data_o = load_data_q;

    assign dmem.dmem_req   = in_req;
    assign dmem.dmem_we    = in_req & we_q;
    assign dmem.dmem_addr  = {addr_q[63:3], 3'b000};
    assign dmem.dmem_wmask = in_req ? al_wmask : 8'h00;
    assign dmem.dmem_wdata = in_req ? al_wdata : 64'h0;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: a vector table of single accesses plus
// hand-written timeout, reset, ignored-start and start-in-DONE sequences.
module tb_lsu_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, is_load, is_store;
    logic [2:0]  funct3;
    logic [63:0] addr, sdata;
    logic        busy, done, misalign, bus_err;
    logic [63:0] load_data;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_ld;

    lsu_dmem_if dmem ();

    lsu_mem_stage #(.TIMEOUT_CYCLES(4)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .is_load_i    (is_load),
        .is_store_i   (is_store),
        .funct3_i     (funct3),
        .addr_i       (addr),
        .store_data_i (sdata),
        .busy_o       (busy),
        .done_o       (done),
        .load_data_o  (load_data),
        .misalign_o   (misalign),
        .bus_err_o    (bus_err),
        .dmem         (dmem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] sd;
        logic [63:0] rdata;
        int          k;
        logic        ill;
        logic [7:0]  wmask;
        logic [63:0] wdata;
        logic [63:0] ld;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_acc(input logic st, input logic [2:0] f3, input logic [63:0] a,
                             input logic [63:0] d);
        start    = 1'b1;
        is_store = st;
        is_load  = ~st;
        funct3   = f3;
        addr     = a;
        sdata    = d;
    endtask

    task automatic idle_in();
        start    = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        drive_acc(v.st, v.f3, v.addr, v.sd);
        #1;
        chk($sformatf("v%0d_busy_accept", i), busy, !v.ill);
        chk($sformatf("v%0d_req_accept", i), dmem.dmem_req, 1'b0);
        nxt();
        idle_in();
        if (v.ill) begin
            #1;
            chk($sformatf("v%0d_done", i), done, 1'b1);
            chk($sformatf("v%0d_misalign", i), misalign, 1'b1);
            chk($sformatf("v%0d_bus_err", i), bus_err, 1'b0);
            chk($sformatf("v%0d_no_req", i), dmem.dmem_req, 1'b0);
            chk($sformatf("v%0d_ld_kept", i), load_data, exp_ld);
            nxt();
        end else begin
            for (int c = 1; c <= v.k; c++) begin
                if (c == v.k) begin
                    dmem.dmem_ack   = 1'b1;
                    dmem.dmem_rdata = v.rdata;
                end
                #1;
                chk($sformatf("v%0d_c%0d_req", i, c), dmem.dmem_req, 1'b1);
                chk($sformatf("v%0d_c%0d_busy", i, c), busy, 1'b1);
                chk($sformatf("v%0d_c%0d_we", i, c), dmem.dmem_we, v.st);
                chk($sformatf("v%0d_c%0d_addr", i, c), dmem.dmem_addr, {v.addr[63:3], 3'b000});
                chk($sformatf("v%0d_c%0d_wmask", i, c), dmem.dmem_wmask, v.wmask);
                chk($sformatf("v%0d_c%0d_wdata", i, c), dmem.dmem_wdata, v.wdata);
                nxt();
                dmem.dmem_ack   = 1'b0;
                dmem.dmem_rdata = '0;
            end
            #1;
            if (!v.st) exp_ld = v.ld;
            chk($sformatf("v%0d_done", i), done, 1'b1);
            chk($sformatf("v%0d_busy_done", i), busy, 1'b0);
            chk($sformatf("v%0d_misalign", i), misalign, 1'b0);
            chk($sformatf("v%0d_bus_err", i), bus_err, 1'b0);
            chk($sformatf("v%0d_req_done", i), dmem.dmem_req, 1'b0);
            chk($sformatf("v%0d_load_data", i), load_data, exp_ld);
            nxt();
        end
    endtask

    initial begin
        vt[0]  = '{1'b1, 3'b000, 64'h1003, 64'hAB, 64'h0, 2, 1'b0, 8'h08, 64'hAB00_0000, 64'h0};
        vt[1]  = '{1'b0, 3'b001, 64'h2006, 64'h0, 64'h8001_0000_0000_0000, 1, 1'b0, 8'hC0, 64'h0,
                   64'hFFFF_FFFF_FFFF_8001};
        vt[2]  = '{1'b0, 3'b101, 64'h2006, 64'h0, 64'h8001_0000_0000_0000, 3, 1'b0, 8'hC0, 64'h0,
                   64'h0000_0000_0000_8001};
        vt[3]  = '{1'b0, 3'b010, 64'h3002, 64'h0, 64'h0, 1, 1'b1, 8'h00, 64'h0, 64'h0};
        vt[4]  = '{1'b1, 3'b011, 64'h5000, 64'h0123_4567_89AB_CDEF, 64'h0, 1, 1'b0, 8'hFF,
                   64'h0123_4567_89AB_CDEF, 64'h0};
        vt[5]  = '{1'b0, 3'b011, 64'h5000, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 1'b0, 8'hFF, 64'h0,
                   64'h0123_4567_89AB_CDEF};
        vt[6]  = '{1'b0, 3'b000, 64'h6005, 64'h0, 64'h0000_8000_0000_0000, 2, 1'b0, 8'h20, 64'h0,
                   64'hFFFF_FFFF_FFFF_FF80};
        vt[7]  = '{1'b0, 3'b100, 64'h6005, 64'h0, 64'h0000_8000_0000_0000, 1, 1'b0, 8'h20, 64'h0,
                   64'h0000_0000_0000_0080};
        vt[8]  = '{1'b0, 3'b110, 64'h7004, 64'h0, 64'hDEAD_BEEF_1234_5678, 1, 1'b0, 8'hF0, 64'h0,
                   64'h0000_0000_DEAD_BEEF};
        vt[9]  = '{1'b0, 3'b010, 64'h7004, 64'h0, 64'hDEAD_BEEF_1234_5678, 1, 1'b0, 8'hF0, 64'h0,
                   64'hFFFF_FFFF_DEAD_BEEF};
        vt[10] = '{1'b1, 3'b001, 64'h8002, 64'hFFFF_FFFF_FFFF_1234, 64'h0, 1, 1'b0, 8'h0C,
                   64'hFFFF_FFFF_1234_0000, 64'h0};
        vt[11] = '{1'b0, 3'b111, 64'h9000, 64'h0, 64'h0, 1, 1'b1, 8'h00, 64'h0, 64'h0};
        vt[12] = '{1'b1, 3'b100, 64'h9000, 64'h0, 64'h0, 1, 1'b1, 8'h00, 64'h0, 64'h0};
        vt[13] = '{1'b1, 3'b011, 64'h9004, 64'h0, 64'h0, 1, 1'b1, 8'h00, 64'h0, 64'h0};
        vt[14] = '{1'b1, 3'b010, 64'hA004, 64'h1122_3344, 64'h0, 2, 1'b0, 8'hF0,
                   64'h1122_3344_0000_0000, 64'h0};

        rst = 1'b1;
        idle_in();
        funct3 = '0;
        addr   = '0;
        sdata  = '0;
        dmem.dmem_ack   = 1'b0;
        dmem.dmem_rdata = '0;
        exp_ld = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_misalign", misalign, 1'b0);
        chk("rst_bus_err", bus_err, 1'b0);
        chk("rst_req", dmem.dmem_req, 1'b0);
        chk("rst_we", dmem.dmem_we, 1'b0);
        chk("rst_addr", dmem.dmem_addr, 64'h0);
        chk("rst_wmask", dmem.dmem_wmask, 8'h00);
        chk("rst_wdata", dmem.dmem_wdata, 64'h0);
        chk("rst_load_data", load_data, 64'h0);
        rst = 1'b0;
        nxt();

        for (int i = 0; i < 15; i++) run_vec(i, vt[i]);

        // start without a direction does nothing
        start = 1'b1;
        #1;
        chk("nodir_busy", busy, 1'b0);
        nxt();
        idle_in();
        #1;
        chk("nodir_req", dmem.dmem_req, 1'b0);
        chk("nodir_done", done, 1'b0);
        nxt();

        // timeout: 4 REQ cycles without ack, then DONE with bus_err
        drive_acc(1'b0, 3'b011, 64'h4000, 64'h0);
        #1;
        chk("to_busy_accept", busy, 1'b1);
        nxt();
        idle_in();
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk($sformatf("to_c%0d_req", c), dmem.dmem_req, 1'b1);
            chk($sformatf("to_c%0d_done", c), done, 1'b0);
            nxt();
        end
        #1;
        chk("to_done", done, 1'b1);
        chk("to_bus_err", bus_err, 1'b1);
        chk("to_misalign", misalign, 1'b0);
        chk("to_req_dropped", dmem.dmem_req, 1'b0);
        chk("to_ld_kept", load_data, exp_ld);
        nxt();
        #1;
        chk("to_idle_done", done, 1'b0);
        chk("to_idle_bus_err", bus_err, 1'b0);

        // start held during DONE is ignored
        drive_acc(1'b0, 3'b011, 64'h5000, 64'h0);
        nxt();
        idle_in();
        dmem.dmem_ack   = 1'b1;
        dmem.dmem_rdata = 64'h55;
        nxt();
        dmem.dmem_ack   = 1'b0;
        dmem.dmem_rdata = '0;
        drive_acc(1'b0, 3'b011, 64'h5000, 64'h0);
        #1;
        exp_ld = 64'h55;
        chk("dstart_done", done, 1'b1);
        chk("dstart_busy", busy, 1'b0);
        chk("dstart_ld", load_data, exp_ld);
        nxt();
        idle_in();
        #1;
        chk("dstart_no_req", dmem.dmem_req, 1'b0);
        chk("dstart_no_done", done, 1'b0);
        nxt();

        // reset in REQ: request drops, late ack is discarded
        drive_acc(1'b0, 3'b011, 64'h4000, 64'h0);
        nxt();
        idle_in();
        #1;
        chk("rreq_req", dmem.dmem_req, 1'b1);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        dmem.dmem_ack   = 1'b1;
        dmem.dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_ld = '0;
        #1;
        chk("rreq_req_dropped", dmem.dmem_req, 1'b0);
        chk("rreq_busy", busy, 1'b0);
        chk("rreq_done0", done, 1'b0);
        chk("rreq_ld_reset", load_data, exp_ld);
        nxt();
        dmem.dmem_ack   = 1'b0;
        dmem.dmem_rdata = '0;
        #1;
        chk("rreq_done1", done, 1'b0);
        nxt();
        #1;
        chk("rreq_done2", done, 1'b0);
        chk("rreq_ld_final", load_data, exp_ld);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the RV64 ALU. It takes the ALU result as the effective address and performs one data-memory access per instruction over a req/ack bus.
- Generates byte masks and lane-shifted store data, and sign- or zero-extends load data.
- Asserts busy to stall the single-cycle core until the access completes.
- Flags misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT_CYCLES, 255: maximum REQ-state cycles without dmem_ack before a bus error is raised. 0 disables the timeout.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  a memory instruction is present this cycle
- is_load  in  1  instruction is a load
- is_store  in  1  instruction is a store; has priority if both is_load and is_store are set
- funct3  in  3  RISC-V funct3: [1:0] size (00 B, 01 H, 10 W, 11 D); [2] unsigned for loads
- addr  in  64  effective address from the ALU res output
- store_data  in  64  rs2 value
- busy  out  1  stall request to the core
- done  out  1  one-cycle completion pulse
- load_data  out  64  extended load result; valid when done is high with no error
- misalign  out  1  with done: address not naturally aligned, or illegal funct3
- bus_err  out  1  with done: timeout expired
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  64  doubleword-aligned address, {addr[63:3], 3'b000}
- dmem_wdata  out  64  store data shifted into its byte lane
- dmem_wmask  out  8  byte enables
- dmem_rdata  in  64  read data, valid with dmem_ack
- dmem_ack  in  1  access complete

Behaviour:
- Reset values: state IDLE; busy, done, misalign, bus_err, dmem_req, dmem_we all 0; dmem_addr, dmem_wdata, dmem_wmask 0; load_data 0; timeout counter 0.
- States:
  - IDLE -> REQ: start and (is_load or is_store) and the access is legal.
  - IDLE -> DONE (misalign=1): start and the access is illegal.
  - REQ -> DONE: dmem_ack=1, or timeout expiry.
  - DONE -> IDLE: always, after one cycle.
- start with neither is_load nor is_store is ignored.
- Illegal access conditions:
  - H with addr[0]≠0.
  - W with addr[1:0]≠0.
  - D with addr[2:0]≠0.
  - Load funct3=111.
  - Store funct3[2]=1.
- Accept cycle:
  - addr, store_data, funct3 and direction are latched.
  - busy is combinationally 1 in this cycle: start && (is_load||is_store) && legal.
- REQ state:
  - busy=1 and dmem_req=1.
  - dmem_we, dmem_addr, dmem_wdata and dmem_wmask are driven from the latched values and held stable until ack.
  - dmem_ack is sampled each cycle.
- Timeout counter:
  - Counts REQ cycles.
  - When it reaches TIMEOUT_CYCLES without ack, dmem_req drops on that edge and the block enters DONE with bus_err=1.
  - Counter clears on leaving REQ.
- Load on ack:
  - Byte lane = dmem_rdata >> (8*addr[2:0]), truncated to the access size.
  - Sign-extended when funct3[2]=0, zero-extended when funct3[2]=1.
  - Result registered into load_data.
  - load_data holds until the next successful load; stores and errors leave it unchanged.
- Store lane generation:
  - wmask: B=8'h01<<a, H=8'h03<<a, W=8'h0F<<a, D=8'hFF, where a = addr[2:0].
  - wdata: store_data << (8*a).
- DONE state:
  - done=1 and busy=0.
  - misalign and bus_err are valid only in this cycle and 0 otherwise.
  - start is ignored in DONE.
- Latency:
  - Accept at cycle 0, dmem_req from cycle 1, ack at cycle k≥1, done at cycle k+1.
  - Minimum 3 cycles from start to next IDLE.
  - Misaligned access: done at cycle 1 with no bus request.
- dmem_ack outside REQ is ignored.
- Reset in any state returns to IDLE at that edge. dmem_req drops and any in-flight ack is discarded.

Decomposition:
- Shared package lsu_pkg:
  - Size encodings SZ_B/SZ_H/SZ_W/SZ_D.
  - State enum IDLE/REQ/DONE.
  - Illegal-funct3 constants.
- Sub-module lsu_align (combinational):
  - Misalignment check.
  - wmask/wdata generation.
  - Load lane extract and extension.
- The top level holds the FSM, latches and timeout counter.

Test Plan:
- SB: addr=0x1003, store_data=0xAB, funct3=000, ack at cycle 2 -> dmem_addr=0x1000, wmask=0x08, wdata=0xAB000000, we=1, done at cycle 3.
- LH: addr=0x2006, rdata=0x8001_0000_0000_0000, funct3=001 -> load_data=0xFFFF_FFFF_FFFF_8001. Same access as LHU -> 0x0000_0000_0000_8001.
- LW: addr=0x3002 -> no dmem_req; done and misalign at cycle 1; load_data unchanged.
- LD: addr=0x4000, TIMEOUT_CYCLES=4, no ack -> dmem_req high for 4 cycles, then done with bus_err=1.
- rst asserted during REQ -> next cycle dmem_req=0, busy=0; a late ack is ignored and no done pulse is produced.
- Back-to-back SD 0x5000 then LD 0x5000 with 1-cycle ack -> wmask=0xFF, then the load returns the stored 64-bit value; busy high except in DONE and IDLE cycles.
